// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: sequencer between issue and an SRAM-like data bus.
//
// Exactly one memory op is in flight at a time. A launch latches the request
// fields, the address phase (REQ) holds data_req high until the bus accepts,
// and the data phase (WAIT) waits for the data/ack. A flush withdraws a request
// that has not been accepted yet. If the request was accepted, the flush kills
// the op: the FSM parks in DRAIN and swallows the bus response that is still
// owed, so no stale result reaches the consumer. Completed ops produce a
// one-cycle resp_valid pulse carrying the tag and load data (0 for stores).

module mem_req_ctrl #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    // issue side
    input  logic             mem_issued,
    input  logic             req_wr,
    input  logic [1:0]       req_size,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             wait_mem,
    // bus side
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    input  logic [31:0]      data_rdata,
    // result side
    output logic             resp_valid,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]       state_q, state_d;

    // latched request fields, held for the whole life of the op
    logic             wr_q;
    logic [1:0]       size_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [TAG_W-1:0] tag_q;

    // registered response
    logic             resp_valid_q, resp_valid_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;

    // FSM decode strobes
    logic             launch;
    logic             complete;

    // Next-state logic; launch and completion strobes fall out of the same decode.
    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                // a launch that coincides with a flush belongs to a killed path
                if (mem_issued && !flush) begin
                    launch  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // data_ok without addr_ok is a bus protocol error and is ignored
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d  = IDLE;
                        complete = !flush;
                    end else begin
                        state_d = flush ? DRAIN : WAIT;
                    end
                end else if (flush) begin
                    // not accepted yet: simply withdraw the request
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (data_data_ok) begin
                    state_d  = IDLE;
                    complete = !flush;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // the bus still owes one response; swallow it, flush is moot here
                if (data_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response next-state: pulse on completion, load data captured at data_ok.
    always_comb begin
        resp_valid_d = complete;
        resp_tag_d   = resp_tag_q;
        resp_rdata_d = resp_rdata_q;
        if (complete) begin
            resp_tag_d   = tag_q;
            resp_rdata_d = wr_q ? 32'd0 : data_rdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request field latch; only written on an accepted launch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            tag_q   <= '0;
        end else if (launch) begin
            wr_q    <= req_wr;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            tag_q   <= req_tag;
        end
    end

    // Response registers; tag and data hold between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
            resp_rdata_q <= 32'd0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign wait_mem   = (state_q != IDLE);
    assign data_req   = (state_q == REQ);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;

    assign resp_valid = resp_valid_q;
    assign resp_tag   = resp_tag_q;
    assign resp_rdata = resp_rdata_q;

    // Protocol monitors: issue must honour wait_mem, bus must not ack an unaccepted request.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(mem_issued && (state_q != IDLE)))
                else $warning("mem_req_ctrl: mem_issued while busy, launch ignored");
            assert (!(data_data_ok && ((state_q == IDLE) || ((state_q == REQ) && !data_addr_ok))))
                else $warning("mem_req_ctrl: data_ok with no accepted request, ignored");
        end
    end

endmodule
